piso_register_reader: RTL and testbench
=======================================

Name: piso_register_reader

Overview:
- Reader side of the parallel register path: accepts one WIDTH-bit word, already written in parallel, on a valid/ready load handshake.
- Drives the word out one bit per accepted transfer on a serial valid/ready stream.
- Sits between register-bank read data and a bit-serial consumer such as a debug/scan readout or a serial link.
- Holds one word at a time and raises busy while shifting.

Parameters:
- WIDTH, 8, word width in bits; must be >= 2.
- LSB_FIRST, 1, 1 = bit 0 is sent first; 0 = bit WIDTH-1 is sent first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- load_valid  input  1  load_data is valid.
- load_ready  output  1  block can accept a word; high only in IDLE.
- load_data  input  WIDTH  parallel word to be read out.
- ser_valid  output  1  ser_out holds a valid bit.
- ser_ready  input  1  consumer accepts the bit this cycle.
- ser_out  output  1  current serial bit.
- ser_last  output  1  marks the final bit of the word; qualified by ser_valid.
- busy  output  1  high in SHIFT.

Behaviour:
- Clocking and reset: single clock domain, clk. rst is asynchronous and active-high.
- On rst: state=IDLE, shift register=0, bit counter=0.
  - Resulting outputs: load_ready=1, ser_valid=0, ser_out=0, ser_last=0, busy=0.
- FSM has two states, IDLE and SHIFT.
- IDLE:
  - load_ready=1, ser_valid=0.
  - ser_out is driven 0 and ser_last is driven 0.
  - Load accepted when load_valid && load_ready at a rising edge. On accept: shift register <= load_data, counter <= 0, state -> SHIFT.
- SHIFT:
  - load_ready=0 and busy=1.
  - ser_valid=1 for every cycle in SHIFT.
  - ser_out = shift register bit 0 when LSB_FIRST=1, else bit WIDTH-1.
  - ser_last = (counter == WIDTH-1).
  - Transfer happens when ser_valid && ser_ready at an edge:
    - Shift register moves one position toward the output end, with zero fill.
    - Counter increments.
    - If ser_last was 1, state -> IDLE.
- Stall: when ser_ready=0 in SHIFT, ser_out, ser_last and the counter hold unchanged for any number of cycles.
- Latency:
  - First bit is valid on the cycle after load accept.
  - With ser_ready held high, a word takes WIDTH cycles in SHIFT plus 1 cycle in IDLE, so the minimum period is WIDTH+1 cycles per word.
- load_valid while busy: ignored and not captured. The upstream holds load_data until load_ready is high.
- Counter: $clog2(WIDTH) bits and never wraps. The exit to IDLE happens at WIDTH-1.
- Outputs: all registered or decoded from state and registers only. No combinational path from ser_ready or load_valid to any output.
- Reset asserted mid-word: the word is abandoned immediately, with no partial completion. After reset release the block is in IDLE with load_ready=1.
- X-safety: the shift register is updated only on load accept or on serial transfer.

Decomposition:
- Shared package piso_pkg holds:
  - typedef enum logic {IDLE, SHIFT} piso_state_t
  - localparam function for counter width, clog2(WIDTH)
- One natural sub-module: shift_reg_piso.
  - Holds the WIDTH-bit register with load and shift enables plus direction selected by LSB_FIRST.
  - Built from the team's flipflop cells in a generate loop, one per bit.
- The FSM and counter live in the top module.

Test Plan:
- Reset, load_data=8'hA5, LSB_FIRST=1, ser_ready=1, one-cycle load pulse:
  - ser_out=1,0,1,0,0,1,0,1 over 8 consecutive cycles starting the cycle after accept.
  - ser_last=1 only on the 8th bit.
  - load_ready=1 on the cycle after the last transfer.
- LSB_FIRST=0, load 8'hA5:
  - ser_out=1,0,1,0,0,1,0,1 (MSB first; the same pattern by symmetry).
  - Repeat with 8'h81 MSB first, expecting 1,0,0,0,0,0,0,1.
  - Repeat with 8'h01 MSB first, expecting ser_last coincident with the only 1.
- Load 8'h3C, hold ser_ready=0 for 5 cycles after bit 2:
  - ser_out, ser_last and busy are frozen during the stall.
  - Remaining bits resume in order afterwards, for 8 transfers total.
- During SHIFT of 8'hF0, present load_valid=1 with load_data=8'h0F:
  - Not captured; the full 8'hF0 stream completes.
  - 8'h0F is accepted on the first IDLE cycle, giving exactly WIDTH+1 cycles between the two load accepts.
- Assert rst asynchronously, between edges, after 3 bits of 8'hFF:
  - ser_valid, busy, ser_out and ser_last go 0 immediately, load_ready goes 1.
  - A subsequent load of 8'h55 streams cleanly from bit 0.
- WIDTH=2, load 2'b10, LSB_FIRST=1:
  - ser_out=0 then 1, with ser_last on the 2nd bit.
  - Counter boundary exits to IDLE with no extra bit.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the parallel-in / serial-out register reader.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    // Bit counter width; a 1-bit floor keeps WIDTH=2 and degenerate values legal.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/shift_reg_piso.sv
// WIDTH-bit load/shift register built from one enable flop per bit; shifts toward
// the output end (bit 0 when LSB_FIRST, bit WIDTH-1 otherwise) with zero fill.
module piso_dff (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q
);

    // NOTE: sequential state always uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= 1'b0;
        else if (en)
            q <= d;
    end

endmodule

module shift_reg_piso #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] shifted;

    if (LSB_FIRST) begin : g_toward_lsb
        assign shifted = {1'b0, q[WIDTH-1:1]};
    end else begin : g_toward_msb
        assign shifted = {q[WIDTH-2:0], 1'b0};
    end

    // Load wins over shift; the register only moves on one of the two enables.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        piso_dff u_dff (
            .clk (clk),
            .rst (rst),
            .en  (load | shift),
            .d   (load ? din[i] : shifted[i]),
            .q   (q[i])
        );
    end

endmodule

// File: rtl/piso_register_reader.sv
// Accepts one parallel word on a load handshake and streams it out one bit per
// accepted transfer on a valid/ready serial interface, flagging the final bit.
module piso_register_reader
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_out,
    output logic             ser_last,
    output logic             busy
);

    localparam int              CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    piso_state_t      state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sreg;
    logic             tap;
    logic             load_acc;
    logic             xfer;

    assign load_acc = load_valid && load_ready;
    assign xfer     = ser_valid && ser_ready;

    shift_reg_piso #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_shift_reg (
        .clk   (clk),
        .rst   (rst),
        .load  (load_acc),
        .shift (xfer),
        .din   (load_data),
        .q     (sreg)
    );

    if (LSB_FIRST) begin : g_tap_lsb
        assign tap = sreg[0];
    end else begin : g_tap_msb
        assign tap = sreg[WIDTH-1];
    end

    // Masked by the registered valid so the line reads 0 whenever IDLE.
    assign ser_out = ser_valid & tap;

    // Handshake flags are registered alongside state so no input reaches an output
    // combinationally; ser_last is precomputed one transfer ahead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            load_ready <= 1'b1;
            ser_valid  <= 1'b0;
            busy       <= 1'b0;
            ser_last   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_acc) begin
                        state      <= SHIFT;
                        cnt        <= '0;
                        load_ready <= 1'b0;
                        ser_valid  <= 1'b1;
                        busy       <= 1'b1;
                        ser_last   <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (xfer) begin
                        if (ser_last) begin
                            state      <= IDLE;
                            load_ready <= 1'b1;
                            ser_valid  <= 1'b0;
                            busy       <= 1'b0;
                            ser_last   <= 1'b0;
                        end else begin
                            cnt      <= cnt + 1'b1;
                            ser_last <= ((cnt + 1'b1) == LAST);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_register_reader.sv
// Self-checking bench: three instances (8-bit LSB-first, 8-bit MSB-first, 2-bit
// LSB-first) checked bit by bit against an arithmetic model of the serial stream.
module tb_piso_register_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       lv [3];
    logic       sr [3];
    logic [7:0] ld [3];
    logic       lr [3];
    logic       sv [3];
    logic       so [3];
    logic       sl [3];
    logic       bz [3];

    int widths [3] = '{8, 8, 2};
    bit lsbf   [3] = '{1'b1, 1'b0, 1'b1};

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int last_acc = 0;
    int prev_acc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    piso_register_reader #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .load_valid(lv[0]), .load_ready(lr[0]), .load_data(ld[0]),
        .ser_valid(sv[0]), .ser_ready(sr[0]), .ser_out(so[0]), .ser_last(sl[0]), .busy(bz[0])
    );

    piso_register_reader #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst(rst), .load_valid(lv[1]), .load_ready(lr[1]), .load_data(ld[1]),
        .ser_valid(sv[1]), .ser_ready(sr[1]), .ser_out(so[1]), .ser_last(sl[1]), .busy(bz[1])
    );

    piso_register_reader #(.WIDTH(2), .LSB_FIRST(1'b1)) u_w2 (
        .clk(clk), .rst(rst), .load_valid(lv[2]), .load_ready(lr[2]), .load_data(ld[2][1:0]),
        .ser_valid(sv[2]), .ser_ready(sr[2]), .ser_out(so[2]), .ser_last(sl[2]), .busy(bz[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // k-th bit on the wire: bit k for LSB-first, bit WIDTH-1-k for MSB-first.
    function automatic logic exp_bit(input int d, input logic [7:0] word, input int k);
        int idx;
        idx = lsbf[d] ? k : widths[d] - 1 - k;
        return word[idx];
    endfunction

    task automatic check_idle(input int d, input string tag);
        check($sformatf("%s_load_ready_d%0d", tag, d), lr[d], 1);
        check($sformatf("%s_ser_valid_d%0d", tag, d), sv[d], 0);
        check($sformatf("%s_busy_d%0d", tag, d), bz[d], 0);
        check($sformatf("%s_ser_out_d%0d", tag, d), so[d], 0);
        check($sformatf("%s_ser_last_d%0d", tag, d), sl[d], 0);
    endtask

    // Called at a negedge in IDLE. pre=1 means load_valid/load_data are already
    // being presented by the caller. stall_at >= width means no stall.
    task automatic send_word(input int d, input logic [7:0] word, input bit pre,
                             input int stall_at, input int stall_len,
                             input bit keep_next, input logic [7:0] next);
        int w;
        logic eb;
        w = widths[d];
        check($sformatf("pre_load_ready_d%0d_%0h", d, word), lr[d], 1);
        if (!pre) begin
            lv[d] = 1'b1;
            ld[d] = word;
        end
        prev_acc = last_acc;
        last_acc = cyc;
        @(negedge clk);
        if (keep_next) ld[d] = next;
        else           lv[d] = 1'b0;
        for (int k = 0; k < w; k++) begin
            eb = exp_bit(d, word, k);
            check($sformatf("ser_valid_d%0d_%0h_b%0d", d, word, k), sv[d], 1);
            check($sformatf("busy_d%0d_%0h_b%0d", d, word, k), bz[d], 1);
            check($sformatf("load_ready_d%0d_%0h_b%0d", d, word, k), lr[d], 0);
            check($sformatf("ser_out_d%0d_%0h_b%0d", d, word, k), so[d], eb);
            check($sformatf("ser_last_d%0d_%0h_b%0d", d, word, k), sl[d], (k == w - 1));
            if (k == stall_at) begin
                sr[d] = 1'b0;
                repeat (stall_len) begin
                    @(negedge clk);
                    check($sformatf("stall_out_d%0d_b%0d", d, k), so[d], eb);
                    check($sformatf("stall_last_d%0d_b%0d", d, k), sl[d], (k == w - 1));
                    check($sformatf("stall_busy_d%0d_b%0d", d, k), bz[d], 1);
                end
                sr[d] = 1'b1;
            end
            @(negedge clk);
        end
        check($sformatf("post_ser_valid_d%0d_%0h", d, word), sv[d], 0);
        check($sformatf("post_ser_last_d%0d_%0h", d, word), sl[d], 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] word;
        int         w;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            lv[d] = 1'b0;
            sr[d] = 1'b1;
            ld[d] = 8'h00;
        end
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) check_idle(d, "reset");
        rst = 1'b0;
        @(negedge clk);

        send_word(0, 8'hA5, 1'b0, 99, 0, 1'b0, 8'h00);
        send_word(1, 8'hA5, 1'b0, 99, 0, 1'b0, 8'h00);
        send_word(1, 8'h81, 1'b0, 99, 0, 1'b0, 8'h00);
        send_word(1, 8'h01, 1'b0, 99, 0, 1'b0, 8'h00);

        send_word(0, 8'h3C, 1'b0, 2, 5, 1'b0, 8'h00);

        // Word offered while busy must wait for IDLE, then go in on the first IDLE cycle.
        send_word(0, 8'hF0, 1'b0, 99, 0, 1'b1, 8'h0F);
        send_word(0, 8'h0F, 1'b1, 99, 0, 1'b0, 8'h00);
        check("accept_spacing", last_acc - prev_acc, widths[0] + 1);

        // Asynchronous reset in the middle of a word, between clock edges.
        lv[0] = 1'b1;
        ld[0] = 8'hFF;
        @(negedge clk);
        lv[0] = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_idle(0, "async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_word(0, 8'h55, 1'b0, 99, 0, 1'b0, 8'h00);

        send_word(2, 8'h02, 1'b0, 99, 0, 1'b0, 8'h00);
        check_idle(2, "w2_exit");

        // Randomized words and stalls on every instance.
        for (int d = 0; d < 3; d++) begin
            w = widths[d];
            repeat (20) begin
                word = 8'($urandom);
                if (w < 8) word = word & 8'((1 << w) - 1);
                send_word(d, word, 1'b0, $urandom_range(0, w), $urandom_range(1, 4), 1'b0, 8'h00);
            end
            check_idle(d, "rand_end");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
